// File: rtl/stream_mux.sv
// stream_mux: N:1 valid/ready stream multiplexer with one registered output
// stage. The channel is picked either by sel (mode=0) or by round-robin
// (mode=1).
// Optional feature: define PKT_LOCK_EN to add in_last/out_last and to keep the
// grant on one channel until the last beat of its packet has been accepted.
module stream_mux #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SELW  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic               mode,
  input  logic [SELW-1:0]    sel,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SELW-1:0]    out_ch
`ifdef PKT_LOCK_EN
  ,
  input  logic [N-1:0]       in_last,
  output logic               out_last
`endif
);

  // Output register and arbitration state
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic [SELW-1:0]  out_ch_q, out_ch_d;
  logic [SELW-1:0]  rr_ptr_q, rr_ptr_d;

  // Arbitration results
  logic             grant_valid;
  logic [SELW-1:0]  grant;
  logic             rr_found;
  logic [SELW-1:0]  rr_ch;
  logic [SELW:0]    rr_idx;
  logic             load;
  logic             xfer;
  logic             beat_last;

  // Per-channel data slices
  logic [WIDTH-1:0] ch_data [N];

`ifdef PKT_LOCK_EN
  logic             lock_q, lock_d;
  logic [SELW-1:0]  lock_ch_q, lock_ch_d;
  logic             out_last_q, out_last_d;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_chan
      assign ch_data[gi]  = in_data[gi*WIDTH +: WIDTH];
      // Only the granted channel sees ready, and only when the stage can load.
      assign in_ready[gi] = xfer & (grant == SELW'(gi));
    end
  endgenerate

  // The output stage can take a new beat when empty or being drained.
  assign load = !out_valid_q | out_ready;
  // Nothing is accepted while reset is asserted.
  assign xfer = load & grant_valid & !rst;

  // Grant selection: packet lock first, then round-robin or fixed select.
  always_comb begin
    grant_valid = 1'b0;
    grant       = '0;
    rr_found    = 1'b0;
    rr_ch       = '0;
    rr_idx      = '0;
    // Round-robin search starting at rr_ptr, wrapping modulo N.
    for (int i = 0; i < N; i++) begin
      rr_idx = {1'b0, rr_ptr_q} + (SELW+1)'(i);
      if (rr_idx >= (SELW+1)'(N)) begin
        rr_idx = rr_idx - (SELW+1)'(N);
      end
      if (!rr_found && in_valid[rr_idx[SELW-1:0]]) begin
        rr_found = 1'b1;
        rr_ch    = rr_idx[SELW-1:0];
      end
    end
`ifdef PKT_LOCK_EN
    if (lock_q) begin
      grant_valid = in_valid[lock_ch_q];
      grant       = lock_ch_q;
    end else
`endif
    if (mode) begin
      grant_valid = rr_found;
      grant       = rr_ch;
    end else if ({1'b0, sel} < (SELW+1)'(N)) begin
      // An out-of-range select grants nothing.
      grant_valid = in_valid[sel];
      grant       = sel;
    end
  end

  // Next-state logic for the output register, round-robin pointer and lock.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    rr_ptr_d    = rr_ptr_q;
    beat_last   = 1'b1;
`ifdef PKT_LOCK_EN
    lock_d      = lock_q;
    lock_ch_d   = lock_ch_q;
    out_last_d  = out_last_q;
    beat_last   = in_last[grant];
`endif
    if (load) begin
      // An empty load cycle clears out_valid; data and channel just hold.
      out_valid_d = grant_valid;
      if (grant_valid) begin
        out_data_d = ch_data[grant];
        out_ch_d   = grant;
`ifdef PKT_LOCK_EN
        out_last_d = in_last[grant];
`endif
      end
    end
    if (xfer) begin
      // The pointer moves past the served channel only at a beat boundary
      // that ends a packet (every beat when packets are not tracked).
      if (mode && beat_last) begin
        rr_ptr_d = (grant == SELW'(N-1)) ? '0 : grant + SELW'(1);
      end
`ifdef PKT_LOCK_EN
      lock_d    = !in_last[grant];
      lock_ch_d = grant;
`endif
    end
  end

  // State registers with synchronous reset; reset drops any held beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      rr_ptr_q    <= '0;
`ifdef PKT_LOCK_EN
      lock_q      <= 1'b0;
      lock_ch_q   <= '0;
      out_last_q  <= 1'b0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      rr_ptr_q    <= rr_ptr_d;
`ifdef PKT_LOCK_EN
      lock_q      <= lock_d;
      lock_ch_q   <= lock_ch_d;
      out_last_q  <= out_last_d;
`endif
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
`ifdef PKT_LOCK_EN
  assign out_last  = out_last_q;
`endif

endmodule
